// File: rtl/cv32e40p_obi_arbiter.sv
// OBI arbiter: lets the instruction and data interfaces of the core share one
// memory port. Requests are arbitrated and held stable until granted. An
// in-order ID FIFO records who issued each granted transaction, so every
// response is routed back to the master that is waiting for it.
module cv32e40p_obi_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ARB_MODE        = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic SEL_INSTR = 1'b0;
    localparam logic SEL_DATA  = 1'b1;

    logic                       lock_q, lock_d;
    logic                       lock_sel_q, lock_sel_d;
    logic                       last_sel_q, last_sel_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;

    logic full_s;
    logic sel_s;
    logic push_s;
    logic pop_s;
    logic head_s;

    // Select the master: a pending lock wins, otherwise priority or round-robin.
    always_comb begin
        full_s    = (cnt_q == CNT_MAX);
        mem_req_o = (instr_req_i | data_req_i) & ~full_s;
        if (lock_q) begin
            sel_s = lock_sel_q;
        end else if ((ARB_MODE == 1) && instr_req_i && data_req_i) begin
            sel_s = ~last_sel_q;
        end else begin
            sel_s = data_req_i ? SEL_DATA : SEL_INSTR;
        end
    end

    // Drive the slave-side address/attributes; zero whenever nothing is requested.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0000_0000;
        mem_wdata_o = 32'h0000_0000;
        if (mem_req_o && (sel_s == SEL_DATA)) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end else if (mem_req_o) begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i;
        end else begin
            mem_we_o    = 1'b0;
        end
    end

    // Route grants to the selected master and responses to the FIFO head.
    always_comb begin
        push_s         = mem_gnt_i & mem_req_o;
        instr_gnt_o    = push_s & (sel_s == SEL_INSTR);
        data_gnt_o     = push_s & (sel_s == SEL_DATA);
        head_s         = id_q[rptr_q];
        pop_s          = mem_rvalid_i & (cnt_q != {CNT_W{1'b0}});
        instr_rvalid_o = pop_s & (head_s == SEL_INSTR);
        data_rvalid_o  = pop_s & (head_s == SEL_DATA);
        instr_rdata_o  = mem_rdata_i;
        data_rdata_o   = mem_rdata_i;
    end

    // Next-state: lock tracking, last winner, ID FIFO push/pop and occupancy.
    always_comb begin
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        last_sel_d = last_sel_q;
        cnt_d      = cnt_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        id_d       = id_q;

        if (!mem_req_o) begin
            lock_d = 1'b0;
        end else if (mem_gnt_i) begin
            lock_d = 1'b0;
        end else begin
            lock_d     = 1'b1;
            lock_sel_d = sel_s;
        end

        if (push_s) begin
            id_d[wptr_q] = sel_s;
            last_sel_d   = sel_s;
            wptr_d       = (wptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wptr_q + PTR_W'(1);
        end else begin
            wptr_d       = wptr_q;
        end

        if (pop_s) begin
            rptr_d = (rptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers; reset empties the FIFO and makes data the last winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_sel_q <= SEL_INSTR;
            last_sel_q <= SEL_DATA;
            cnt_q      <= {CNT_W{1'b0}};
            wptr_q     <= {PTR_W{1'b0}};
            rptr_q     <= {PTR_W{1'b0}};
            id_q       <= {MAX_OUTSTANDING{1'b0}};
        end else begin
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            last_sel_q <= last_sel_d;
            cnt_q      <= cnt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            id_q       <= id_d;
        end
    end

    cv32e40p_obi_arbiter_chk u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mem_rvalid_i (mem_rvalid_i),
        .busy_i       (cnt_q != {CNT_W{1'b0}}),
        .instr_gnt_i  (instr_gnt_o),
        .data_gnt_i   (data_gnt_o)
    );

endmodule

// Simulation-time protocol checks for the arbiter.
module cv32e40p_obi_arbiter_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic mem_rvalid_i,
    input logic busy_i,
    input logic instr_gnt_i,
    input logic data_gnt_i
);

    // Flag responses nobody is waiting for, and any double grant.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_rvalid_i && !busy_i))
                else $warning("obi_arbiter: spurious rvalid with no outstanding transaction, ignored");
            assert (!(instr_gnt_i && data_gnt_i))
                else $error("obi_arbiter: both masters granted in one cycle");
        end
    end

endmodule

// File: tb/tb_cv32e40p_obi_arbiter.sv
// Bench for cv32e40p_obi_arbiter: a fixed-priority and a round-robin instance
// share the same stimulus and are compared every cycle against a queue-based
// model, with directed scenarios pinned by hand-computed values.
module tb_cv32e40p_obi_arbiter;

    localparam int MAXO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b0;
    logic        ireq   = 1'b0;
    logic        dreq   = 1'b0;
    logic        dwe    = 1'b0;
    logic        gnt    = 1'b0;
    logic        rvalid = 1'b0;
    logic [3:0]  dbe    = 4'h0;
    logic [31:0] iaddr  = 32'h0;
    logic [31:0] daddr  = 32'h0;
    logic [31:0] dwdata = 32'h0;
    logic [31:0] rdata  = 32'h0;

    logic [1:0]  o_igr, o_dgr, o_irv, o_drv, o_mreq, o_we;
    logic [3:0]  o_be [2];
    logic [31:0] o_addr [2];
    logic [31:0] o_wdata [2];
    logic [31:0] o_irdata [2];
    logic [31:0] o_drdata [2];

    int checks = 0;
    int errors = 0;

    cv32e40p_obi_arbiter #(.MAX_OUTSTANDING(MAXO), .ARB_MODE(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(ireq), .instr_gnt_o(o_igr[0]), .instr_rvalid_o(o_irv[0]),
        .instr_addr_i(iaddr), .instr_rdata_o(o_irdata[0]),
        .data_req_i(dreq), .data_gnt_o(o_dgr[0]), .data_rvalid_o(o_drv[0]),
        .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr), .data_wdata_i(dwdata),
        .data_rdata_o(o_drdata[0]),
        .mem_req_o(o_mreq[0]), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
        .mem_we_o(o_we[0]), .mem_be_o(o_be[0]), .mem_addr_o(o_addr[0]),
        .mem_wdata_o(o_wdata[0]), .mem_rdata_i(rdata)
    );

    cv32e40p_obi_arbiter #(.MAX_OUTSTANDING(MAXO), .ARB_MODE(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(ireq), .instr_gnt_o(o_igr[1]), .instr_rvalid_o(o_irv[1]),
        .instr_addr_i(iaddr), .instr_rdata_o(o_irdata[1]),
        .data_req_i(dreq), .data_gnt_o(o_dgr[1]), .data_rvalid_o(o_drv[1]),
        .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr), .data_wdata_i(dwdata),
        .data_rdata_o(o_drdata[1]),
        .mem_req_o(o_mreq[1]), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid),
        .mem_we_o(o_we[1]), .mem_be_o(o_be[1]), .mem_addr_o(o_addr[1]),
        .mem_wdata_o(o_wdata[1]), .mem_rdata_i(rdata)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        sel;   // 1 = data
        logic        mreq;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        igr;
        logic        dgr;
        logic        irv;
        logic        drv;
    } exp_t;

    bit m_lock [2] = '{1'b0, 1'b0};
    bit m_lsel [2] = '{1'b0, 1'b0};
    bit m_last [2] = '{1'b1, 1'b1};
    bit q0 [$];
    bit q1 [$];

    function automatic int m_cnt(int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic bit m_head(int m);
        if (m == 0) return (q0.size() > 0) ? q0[0] : 1'b0;
        return (q1.size() > 0) ? q1[0] : 1'b0;
    endfunction

    // Instance m is fixed priority for m==0 and round-robin for m==1.
    function automatic exp_t model_out(int m);
        exp_t e;
        bit   sel;
        int   cnt;
        e   = '0;
        cnt = m_cnt(m);
        if (m_lock[m])                  sel = m_lsel[m];
        else if (m == 1 && ireq && dreq) sel = !m_last[m];
        else                            sel = dreq;
        e.sel  = sel;
        e.mreq = (ireq || dreq) && (cnt < MAXO);
        if (e.mreq && sel) begin
            e.we = dwe; e.be = dbe; e.addr = daddr; e.wdata = dwdata;
        end else if (e.mreq) begin
            e.be = 4'hF; e.addr = iaddr;
        end
        e.igr = gnt && e.mreq && !sel;
        e.dgr = gnt && e.mreq && sel;
        e.irv = rvalid && (cnt > 0) && !m_head(m);
        e.drv = rvalid && (cnt > 0) && m_head(m);
        return e;
    endfunction

    // Advance the model on every clock edge, clear it on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                m_lock[m] = 1'b0; m_lsel[m] = 1'b0; m_last[m] = 1'b1;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int m = 0; m < 2; m++) begin
                exp_t e;
                e = model_out(m);
                if (m == 0) begin
                    if (e.irv || e.drv) void'(q0.pop_front());
                    if (e.igr || e.dgr) q0.push_back(e.sel);
                end else begin
                    if (e.irv || e.drv) void'(q1.pop_front());
                    if (e.igr || e.dgr) q1.push_back(e.sel);
                end
                if (e.igr || e.dgr) m_last[m] = e.sel;
                if (!e.mreq)        m_lock[m] = 1'b0;
                else if (gnt)       m_lock[m] = 1'b0;
                else begin
                    m_lock[m] = 1'b1; m_lsel[m] = e.sel;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model each cycle.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            exp_t e;
            e = model_out(m);
            chk($sformatf("mem_req m%0d", m),   32'(o_mreq[m]), 32'(e.mreq));
            chk($sformatf("mem_we m%0d", m),    32'(o_we[m]),   32'(e.we));
            chk($sformatf("mem_be m%0d", m),    32'(o_be[m]),   32'(e.be));
            chk($sformatf("mem_addr m%0d", m),  o_addr[m],      e.addr);
            chk($sformatf("mem_wdata m%0d", m), o_wdata[m],     e.wdata);
            chk($sformatf("instr_gnt m%0d", m), 32'(o_igr[m]),  32'(e.igr));
            chk($sformatf("data_gnt m%0d", m),  32'(o_dgr[m]),  32'(e.dgr));
            chk($sformatf("instr_rv m%0d", m),  32'(o_irv[m]),  32'(e.irv));
            chk($sformatf("data_rv m%0d", m),   32'(o_drv[m]),  32'(e.drv));
            chk($sformatf("instr_rdata m%0d", m), o_irdata[m],  rdata);
            chk($sformatf("data_rdata m%0d", m),  o_drdata[m],  rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        dbe = 4'h0; iaddr = 32'h0; daddr = 32'h0; dwdata = 32'h0; rdata = 32'h0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        tick();
        tick();
        // reset state
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst mem_req", 32'(o_mreq[m]), 32'd0);
            chk("rst addr", o_addr[m], 32'd0);
            chk("rst grants", 32'({o_igr[m], o_dgr[m]}), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("post-rst outputs", 32'({o_mreq[m], o_irv[m], o_drv[m], o_be[m]}), 32'd0);
        tick();

        // single instruction read
        ireq = 1'b1; iaddr = 32'h80; gnt = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("t1 instr_gnt", 32'(o_igr[m]), 32'd1);
            chk("t1 data_gnt", 32'(o_dgr[m]), 32'd0);
            chk("t1 be", 32'(o_be[m]), 32'hF);
            chk("t1 we", 32'(o_we[m]), 32'd0);
            chk("t1 addr", o_addr[m], 32'h80);
        end
        tick();
        ireq = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h13;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("t1 instr_rvalid", 32'(o_irv[m]), 32'd1);
            chk("t1 data_rvalid", 32'(o_drv[m]), 32'd0);
            chk("t1 instr_rdata", o_irdata[m], 32'h13);
        end
        tick();
        rvalid = 1'b0;

        // simultaneous requests, fixed priority: data then instr
        ireq = 1'b1; dreq = 1'b1; daddr = 32'h1000; dbe = 4'hF; gnt = 1'b1;
        @(negedge clk);
        chk("t2 first data_gnt", 32'(o_dgr[0]), 32'd1);
        chk("t2 first instr_gnt", 32'(o_igr[0]), 32'd0);
        tick();
        dreq = 1'b0;
        @(negedge clk);
        chk("t2 second instr_gnt", 32'(o_igr[0]), 32'd1);
        tick();
        ireq = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hD0;
        @(negedge clk);
        chk("t2 rsp1 data_rvalid", 32'(o_drv[0]), 32'd1);
        chk("t2 rsp1 instr_rvalid", 32'(o_irv[0]), 32'd0);
        tick();
        rdata = 32'h10;
        @(negedge clk);
        chk("t2 rsp2 instr_rvalid", 32'(o_irv[0]), 32'd1);
        tick();
        idle();

        // round-robin after reset: instr, data, instr, data
        pulse_reset();
        ireq = 1'b1; dreq = 1'b1; gnt = 1'b1; iaddr = 32'h40; daddr = 32'h2000; dbe = 4'h1;
        for (int k = 0; k < 4; k++) begin
            rvalid = (k > 0);
            @(negedge clk);
            chk($sformatf("t3 rr instr_gnt %0d", k), 32'(o_igr[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3 rr data_gnt %0d", k),  32'(o_dgr[1]), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("t3 fp data_gnt %0d", k),  32'(o_dgr[0]), 32'd1);
            tick();
        end
        idle();
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;

        // lock holds data attributes while the slave stalls
        dreq = 1'b1; daddr = 32'hA5A5_0040; dwe = 1'b1; dbe = 4'h3; dwdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                ireq = 1'b1; iaddr = 32'h100;
            end
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                chk("t4 lock addr", o_addr[m], 32'hA5A5_0040);
                chk("t4 lock we", 32'(o_we[m]), 32'd1);
                chk("t4 lock be", 32'(o_be[m]), 32'h3);
                chk("t4 lock wdata", o_wdata[m], 32'hDEAD_BEEF);
            end
            tick();
        end
        gnt = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("t4 data_gnt after stall", 32'(o_dgr[m]), 32'd1);
        tick();
        dreq = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("t4 instr_gnt next", 32'(o_igr[m]), 32'd1);
        tick();
        idle();
        rvalid = 1'b1;
        tick();
        tick();
        rvalid = 1'b0;

        // full boundary
        ireq = 1'b1; iaddr = 32'h200; gnt = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("t5 full mem_req", 32'(o_mreq[0]), 32'd0);
        chk("t5 full cnt", 32'(u_dut0.cnt_q), 32'd2);
        tick();
        rvalid = 1'b1; rdata = 32'h55;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("t5 rvalid cycle mem_req", 32'(o_mreq[m]), 32'd0);
            chk("t5 rvalid cycle instr_gnt", 32'(o_igr[m]), 32'd0);
            chk("t5 rvalid cycle instr_rvalid", 32'(o_irv[m]), 32'd1);
        end
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        chk("t5 resume instr_gnt", 32'(o_igr[0]), 32'd1);
        tick();
        @(negedge clk);
        chk("t5 cnt back to 2", 32'(u_dut0.cnt_q), 32'd2);
        chk("t5 blocked again", 32'(o_mreq[0]), 32'd0);
        tick();
        idle();
        rvalid = 1'b1;
        tick();
        tick();
        rvalid = 1'b0;

        // reset with outstanding transactions, then a spurious rvalid
        ireq = 1'b1; gnt = 1'b1;
        tick();
        tick();
        idle();
        pulse_reset();
        rvalid = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 2; m++) chk("t6 spurious rvalids", 32'({o_irv[m], o_drv[m]}), 32'd0);
        tick();
        chk("t6 cnt m0", 32'(u_dut0.cnt_q), 32'd0);
        chk("t6 cnt m1", 32'(u_dut1.cnt_q), 32'd0);
        rvalid = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            ireq   = ($urandom_range(0, 3) != 0);
            dreq   = ($urandom_range(0, 2) == 0);
            iaddr  = $urandom;
            daddr  = $urandom;
            dwdata = $urandom;
            dwe    = 1'($urandom_range(0, 1));
            dbe    = 4'($urandom_range(0, 15));
            gnt    = 1'($urandom_range(0, 1));
            rvalid = (m_cnt(0) > 0) && ($urandom_range(0, 2) != 0);
            rdata  = $urandom;
            tick();
        end
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_obi_arbiter.md
Name: cv32e40p_obi_arbiter

Overview:
- Shares one OBI memory port between the core's instruction and data interfaces, for single-port-memory FPGA builds.
- Instantiated beside the core, between the core's instr_*/data_* ports and one memory slave.
- Arbitrates requests, holds the selection stable until grant, and tracks outstanding transactions in order so each rvalid reaches the requester that issued it.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (1..4).
- ARB_MODE, 0, 0 = fixed priority (data over instr); 1 = round-robin.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- instr_req_i  in  1  instruction request
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_addr_i  in  32  instruction address
- instr_rdata_o  out  32  instruction read data
- data_req_i  in  1  data request
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_addr_i  in  32  data address
- data_wdata_i  in  32  data write data
- data_rdata_o  out  32  data read data
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  32  memory address
- mem_wdata_o  out  32  memory write data
- mem_rdata_i  in  32  memory read data

Interface: one clock, clk_i; reset rst_ni is asynchronous and active-low.

Behaviour:
- State: lock_q/lock_sel_q, last_sel_q, ID FIFO (MAX_OUTSTANDING entries of 1 bit, 0=instr, 1=data), cnt_q.
- Reset clears all state: FIFO empty, cnt_q=0, lock_q=0, last_sel_q=data.
- With inputs idle, all outputs are 0 immediately after reset.
- Reset mid-transaction discards outstanding IDs; the memory slave must be reset together with this block.
- full = (cnt_q == MAX_OUTSTANDING).
- mem_req_o = (instr_req_i | data_req_i) & !full. It is combinational, zero-cycle latency.
- Selection when lock_q=0, ARB_MODE=0: data if data_req_i, else instr.
- Selection when lock_q=0, ARB_MODE=1: if both request, pick the master not equal to last_sel_q; otherwise pick the sole requester.
- Selection when lock_q=1: lock_sel_q, regardless of the other requester.
- Lock: if mem_req_o=1 and mem_gnt_i=0, set lock_q=1 and lock_sel_q=sel. Clear lock_q on the cycle mem_gnt_i=1. This keeps the slave-side address/attributes stable per OBI.
- Mux for sel=data: mem_addr/we/be/wdata = data_*.
- Mux for sel=instr: mem_addr_o=instr_addr_i, mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
- Mux when mem_req_o=0: all address/attribute outputs are 0.
- Grant: instr_gnt_o / data_gnt_o = mem_gnt_i & mem_req_o & (sel matches). Never both high.
- On grant: push sel into FIFO and set last_sel_q=sel.
- Response: rvalid routed by FIFO head.
  - instr_rvalid_o = mem_rvalid_i & cnt_q!=0 & head==0.
  - data_rvalid_o = mem_rvalid_i & cnt_q!=0 & head==1.
  - Pop on a routed rvalid.
- mem_rdata_i is broadcast to both rdata outputs unconditionally.
- Count update: grant and rvalid in the same cycle leaves cnt_q unchanged (push and pop both performed). A response can arrive the cycle after its grant.
- Full boundary: when full, no request or grant is issued, even if mem_rvalid_i is high in that same cycle. Issue resumes the following cycle.
- Spurious rvalid with cnt_q=0: both rvalid outputs stay 0, state is unchanged; a simulation-only assertion fires.
- Requester behaviour assumed by the design: requester deasserting req before gnt is an OBI violation and not supported. If a locked master drops req anyway, lock_q clears when mem_req_o falls.
- FIFO pointers wrap modulo MAX_OUTSTANDING.

Test Plan:
- Single instr read: instr_req_i=1, addr 0x80, gnt in the same cycle, rvalid next cycle with 0x00000013 → instr_gnt_o=1 for 1 cycle; instr_rvalid_o=1, instr_rdata_o=0x13; data_rvalid_o=0; mem_be_o=4'hF, mem_we_o=0.
- Simultaneous requests, ARB_MODE=0, mem_gnt_i=1 always → data granted first, instr next cycle; responses route data then instr.
- Simultaneous requests held for 4 grants, ARB_MODE=1 → grants alternate instr, data, instr, data (last_sel_q reset=data, so instr goes first).
- Lock: data request, mem_gnt_i=0 for 3 cycles, instr_req_i raised in cycle 2 → mem_addr_o/we/be/wdata stay on the data values for all 3 cycles; data granted on cycle 4.
- Full: MAX_OUTSTANDING=2, two grants with no rvalid → third request sees mem_req_o=0. rvalid plus pending request in the same cycle → still blocked that cycle; granted the next cycle; cnt returns to 2.
- Reset with 2 outstanding, then a spurious rvalid → both rvalid outputs 0, cnt_q=0, assertion fires.
